// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared encodings and helpers for the byte-wide RAM arbiter
package mem_arbiter_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam logic [31:0] ZeroWord    = 32'h0000_0000;
    localparam int          InstAddrBus = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_IF  = 2'd1,
        BUSY_MEM = 2'd2
    } arb_state_e;

    // Size code 3 is illegal and is serviced as a full word.
    function automatic logic [2:0] size_to_beats(input logic [1:0] sz);
        case (sz)
            SZ_B:    return 3'd1;
            SZ_H:    return 3'd2;
            SZ_W:    return 3'd4;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter_byte_assembler.sv
// rtl/mem_arbiter_byte_assembler.sv - beat counter, little-endian byte capture and done pulse
module byte_assembler
    import mem_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic        i_busy,
    input  logic        i_abort,
    input  logic        i_read,
    input  logic [2:0]  i_len,
    input  logic [7:0]  i_ram_dout,
    output logic [2:0]  o_beat,
    output logic        o_last,
    output logic        o_done,
    output logic [31:0] o_word
);

    logic [2:0]  r_beat;
    logic [31:0] r_cap;
    logic        r_done;
    logic [31:0] w_word;

    // Reads finish one beat later than writes because RAM data lags its address by a cycle.
    always_comb begin
        o_last = i_busy && (i_read ? (r_beat == i_len) : (r_beat == i_len - 3'd1));
    end

    // Byte for beat r_beat-1 is on ram_dout now; merge it so the final edge sees the whole word.
    always_comb begin
        w_word = r_cap;
        for (int k = 0; k < 4; k++) begin
            if (r_beat == 3'(k + 1)) begin
                w_word[8*k +: 8] = i_ram_dout;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat <= 3'd0;
            r_cap  <= ZeroWord;
            r_done <= 1'b0;
        end else begin
            r_done <= o_last && !i_abort;
            if (i_start) begin
                r_beat <= 3'd0;
                r_cap  <= ZeroWord;
            end else if (i_busy) begin
                r_beat <= r_beat + 3'd1;
                if (i_read && r_beat != 3'd0) begin
                    r_cap <= w_word;
                end
            end
        end
    end

    assign o_beat = r_beat;
    assign o_done = r_done;
    assign o_word = w_word;

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one byte-wide RAM port between instruction fetch and the MEM stage
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = InstAddrBus
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_done,
    output logic [31:0]       if_inst,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_size,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              mem_done,
    output logic [31:0]       mem_rdata,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr,
    output logic [7:0]        ram_din,
    input  logic [7:0]        ram_dout
);

    arb_state_e        r_state;
    arb_state_e        w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [31:0]       r_wdata;
    logic [2:0]        r_len;
    logic              r_is_if;

    logic              w_grant_mem;
    logic              w_grant_if;
    logic              w_busy;
    logic              w_abort;
    logic              w_last;
    logic              w_done;
    logic [2:0]        w_beat;
    logic [1:0]        w_lane;
    logic [7:0]        w_din_nxt;
    logic [31:0]       w_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_mem) begin
                    w_state_nxt = BUSY_MEM;
                end else if (w_grant_if) begin
                    w_state_nxt = BUSY_IF;
                end
            end
            BUSY_IF: begin
                if (if_flush || w_last) begin
                    w_state_nxt = IDLE;
                end
            end
            BUSY_MEM: begin
                if (w_last) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // A requester whose done is high is still dropping its req, so it must not be re-granted.
    always_comb begin
        w_busy      = (r_state != IDLE);
        w_abort     = (r_state == BUSY_IF) && if_flush;
        w_grant_mem = (r_state == IDLE) && mem_req && !mem_done;
        w_grant_if  = (r_state == IDLE) && !w_grant_mem && if_req && !if_done && !if_flush;
    end

    byte_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_grant_mem || w_grant_if),
        .i_busy     (w_busy),
        .i_abort    (w_abort),
        .i_read     (!r_we),
        .i_len      (r_len),
        .i_ram_dout (ram_dout),
        .o_beat     (w_beat),
        .o_last     (w_last),
        .o_done     (w_done),
        .o_word     (w_word)
    );

    assign w_lane = 2'(w_beat + 3'd1);

    always_comb begin
        case (w_lane)
            2'd1:    w_din_nxt = r_wdata[15:8];
            2'd2:    w_din_nxt = r_wdata[23:16];
            2'd3:    w_din_nxt = r_wdata[31:24];
            default: w_din_nxt = r_wdata[7:0];
        endcase
    end

    // RAM port is registered: the grant edge presents beat 0, each busy edge presents the next beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr    <= '0;
            r_we      <= 1'b0;
            r_wdata   <= ZeroWord;
            r_len     <= 3'd0;
            r_is_if   <= 1'b0;
            ram_a     <= '0;
            ram_wr    <= 1'b0;
            ram_din   <= 8'h00;
            if_inst   <= ZeroWord;
            mem_rdata <= ZeroWord;
        end else begin
            if (w_grant_mem || w_grant_if) begin
                r_addr  <= w_grant_mem ? mem_addr : if_addr;
                r_we    <= w_grant_mem && mem_we;
                r_wdata <= mem_wdata;
                r_len   <= w_grant_mem ? size_to_beats(mem_size) : 3'd4;
                r_is_if <= w_grant_if;
                ram_a   <= w_grant_mem ? mem_addr : if_addr;
                ram_wr  <= w_grant_mem && mem_we;
                ram_din <= mem_wdata[7:0];
            end else if (w_busy && !w_abort && (w_beat + 3'd1 < r_len)) begin
                ram_a   <= r_addr + ADDR_W'(w_beat) + ADDR_W'(1);
                ram_wr  <= r_we;
                ram_din <= w_din_nxt;
            end else begin
                ram_wr  <= 1'b0;
            end

            if (w_last && !r_we && !w_abort) begin
                if (r_state == BUSY_IF) begin
                    if_inst <= w_word;
                end else begin
                    mem_rdata <= w_word;
                end
            end
        end
    end

    assign if_done  = w_done && r_is_if;
    assign mem_done = w_done && !r_is_if;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a byte-addressed RAM model
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic        if_flush = 1'b0;
    logic        if_done;
    logic [31:0] if_inst;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [1:0]  mem_size = 2'd0;
    logic [31:0] mem_addr = 32'h0;
    logic [31:0] mem_wdata = 32'h0;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic [31:0] ram_a;
    logic        ram_wr;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout = 8'h00;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  dev_mem [bit [31:0]];
    logic [7:0]  ref_mem [bit [31:0]];
    logic [31:0] if_q [$];
    logic [31:0] mem_q [$];
    logic [39:0] wq [$];
    logic [31:0] last_load = 32'h0;

    mem_arbiter #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_done(if_done), .if_inst(if_inst),
        .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_done(mem_done), .mem_rdata(mem_rdata),
        .ram_a(ram_a), .ram_wr(ram_wr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] dflt(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h3C;
    endfunction

    function automatic logic [7:0] dev_rd(input logic [31:0] a);
        return dev_mem.exists(a) ? dev_mem[a] : dflt(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    // Synchronous-read RAM: data for the address presented in a cycle appears the next cycle.
    always @(posedge clk) begin
        ram_dout <= dev_rd(ram_a);
        if (ram_wr) dev_mem[ram_a] = ram_din;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic poke(input logic [31:0] a, input logic [7:0] b);
        ref_mem[a] = b;
        dev_mem[a] = b;
    endtask

    // Monitor: pops expected responses whenever the DUT presents a done or a write beat.
    always @(negedge clk) begin
        if (if_done) begin
            if (if_q.size() == 0) check("unexpected_if_done", 32'd1, 32'd0);
            else check("if_inst", if_inst, if_q.pop_front());
        end
        if (mem_done) begin
            if (mem_q.size() == 0) check("unexpected_mem_done", 32'd1, 32'd0);
            else check("mem_rdata", mem_rdata, mem_q.pop_front());
        end
        if (ram_wr) begin
            if (wq.size() == 0) check("unexpected_write", ram_a, 32'hFFFF_FFFF);
            else begin
                logic [39:0] w;
                w = wq.pop_front();
                check("write_addr", ram_a, w[39:8]);
                check("write_data", {24'h0, ram_din}, {24'h0, w[7:0]});
            end
        end
    end

    task automatic expect_txn(input bit is_if, input bit we, input int n,
                              input logic [31:0] addr, input logic [31:0] wd);
        logic [31:0] e;
        e = 32'h0;
        for (int i = 0; i < n; i++) begin
            if (we) begin
                ref_mem[addr + 32'(i)] = wd[8*i +: 8];
                wq.push_back({addr + 32'(i), wd[8*i +: 8]});
            end else begin
                e[8*i +: 8] = ref_rd(addr + 32'(i));
            end
        end
        if (is_if) if_q.push_back(e);
        else if (we) mem_q.push_back(last_load);
        else begin
            mem_q.push_back(e);
            last_load = e;
        end
    endtask

    task automatic run_txn(input bit is_if, input bit we, input logic [1:0] sz,
                           input logic [31:0] addr, input logic [31:0] wd);
        int  n, lat, k;
        bit  got, a_ok;
        n   = is_if ? 4 : (sz == 2'd0 ? 1 : (sz == 2'd1 ? 2 : 4));
        lat = we ? n + 1 : n + 2;
        expect_txn(is_if, we, n, addr, wd);
        @(negedge clk);
        if (is_if) begin
            if_req = 1'b1; if_addr = addr;
        end else begin
            mem_req = 1'b1; mem_we = we; mem_size = sz; mem_addr = addr; mem_wdata = wd;
        end
        k = 0; got = 1'b0; a_ok = 1'b1;
        while (!got && k < lat + 4) begin
            @(negedge clk);
            k++;
            if (k <= n && ram_a !== addr + 32'(k - 1)) a_ok = 1'b0;
            got = is_if ? if_done : mem_done;
        end
        check(is_if ? "if_latency" : "mem_latency", k, lat);
        check("ram_a_sequence", {31'h0, a_ok}, 32'd1);
        if_req = 1'b0;
        mem_req = 1'b0;
    endtask

    task automatic flush_fetch(input logic [31:0] addr, input int fc);
        int seen;
        seen = 0;
        @(negedge clk);
        if_req = 1'b1; if_addr = addr;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == fc) if_flush = 1'b1;
            if (k == fc + 1) begin if_flush = 1'b0; if_req = 1'b0; end
            if (if_done) seen++;
        end
        check("flush_no_done", seen, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          k, kd_mem, kd_if;
        bit          isif, we;
        logic [1:0]  sz;
        logic [31:0] a;

        repeat (3) @(negedge clk);
        check("reset_if_done",   {31'h0, if_done},  32'h0);
        check("reset_if_inst",   if_inst,           32'h0);
        check("reset_mem_done",  {31'h0, mem_done}, 32'h0);
        check("reset_mem_rdata", mem_rdata,         32'h0);
        check("reset_ram_a",     ram_a,             32'h0);
        check("reset_ram_wr_din", {23'h0, ram_wr, ram_din}, 32'h0);
        rst = 1'b0;

        // Word fetch
        poke(32'h100, 8'h13); poke(32'h101, 8'h00); poke(32'h102, 8'h00); poke(32'h103, 8'h93);
        run_txn(1'b1, 1'b0, 2'd2, 32'h100, 32'h0);
        check("fetch_word", if_inst, 32'h9300_0013);

        // Simultaneous requests: MEM wins, IF follows
        poke(32'h20, 8'hF5);
        expect_txn(1'b0, 1'b0, 1, 32'h20, 32'h0);
        expect_txn(1'b1, 1'b0, 4, 32'h0, 32'h0);
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h0;
        mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'd0; mem_addr = 32'h20;
        k = 0; kd_mem = 0; kd_if = 0;
        while (kd_if == 0 && k < 30) begin
            @(negedge clk);
            k++;
            if (mem_done) begin kd_mem = k; mem_req = 1'b0; end
            if (if_done)  begin kd_if = k;  if_req = 1'b0; end
        end
        check("simul_mem_done_cycle", kd_mem, 3);
        check("simul_if_done_cycle", kd_if, 9);
        check("simul_load_byte", mem_rdata, 32'h0000_00F5);

        // Half store, then read back the word around it
        run_txn(1'b0, 1'b1, 2'd1, 32'h40, 32'hDEAD_BEEF);
        run_txn(1'b0, 1'b0, 2'd2, 32'h40, 32'h0);

        // Flush mid-fetch and on the final capture edge, then a clean fetch
        flush_fetch(32'h300, 3);
        flush_fetch(32'h304, 5);
        run_txn(1'b1, 1'b0, 2'd2, 32'h200, 32'h0);

        // Flush in IDLE delays the IF grant by one cycle
        expect_txn(1'b1, 1'b0, 4, 32'h208, 32'h0);
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h208; if_flush = 1'b1;
        k = 0; kd_if = 0;
        while (kd_if == 0 && k < 20) begin
            @(negedge clk);
            k++;
            if (k == 1) if_flush = 1'b0;
            if (if_done) begin kd_if = k; if_req = 1'b0; end
        end
        check("idle_flush_if_done_cycle", kd_if, 7);

        // Address wrap
        run_txn(1'b1, 1'b0, 2'd2, 32'hFFFF_FFFE, 32'h0);

        // Reset in cycle 2 of a word store: only the first two beats land
        ref_mem[32'h80] = 8'h44; wq.push_back({32'h80, 8'h44});
        ref_mem[32'h81] = 8'h33; wq.push_back({32'h81, 8'h33});
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'd2; mem_addr = 32'h80; mem_wdata = 32'h1122_3344;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1; mem_req = 1'b0;
        @(negedge clk);
        check("rst_ram_wr",    {31'h0, ram_wr},   32'h0);
        check("rst_ram_a",     ram_a,             32'h0);
        check("rst_mem_done",  {31'h0, mem_done}, 32'h0);
        check("rst_mem_rdata", mem_rdata,         32'h0);
        check("rst_if_inst",   if_inst,           32'h0);
        rst = 1'b0;
        last_load = 32'h0;
        repeat (4) @(negedge clk);
        run_txn(1'b0, 1'b0, 2'd2, 32'h80, 32'h0);

        // Randomized traffic over a small overlapping window plus the top of memory
        for (int t = 0; t < 40; t++) begin
            isif = ($urandom_range(0, 2) == 0);
            we   = !isif && ($urandom_range(0, 1) == 1);
            sz   = 2'($urandom_range(0, 3));
            a    = 32'h1000 + 32'($urandom_range(0, 12));
            if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            run_txn(isif, we, sz, a, $urandom);
        end

        repeat (4) @(negedge clk);
        check("if_queue_drained",  if_q.size(),  0);
        check("mem_queue_drained", mem_q.size(), 0);
        check("write_queue_drained", wq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
